// File: rtl/pixel_pack_writer.sv
// Packs renderer pixels of a 1-bpp 256x256 bitmap into masked byte writes and drains them
// through a small FIFO to a synchronous RAM port. Define PIX_COUNT_EN to add the pix_count output.
module pixel_pack_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        po,
    input  logic [7:0]  xo,
    input  logic [7:0]  yo,
    input  logic        flush,
    input  logic        clr,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ready,
    output logic        overflow,
    output logic        idle
`ifdef PIX_COUNT_EN
    ,
    output logic [15:0] pix_count
`endif
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(32'd1);
    localparam bit            TMO_EN   = (TIMEOUT != 32'd0);
    localparam logic [7:0]    TMO_LAST = 8'((TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1));

    logic [12:0]   acc_addr_q, acc_addr_d;
    logic [7:0]    acc_mask_q, acc_mask_d;
    logic          acc_v_q, acc_v_d;
    logic          dfl_q, dfl_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          mem_we_q, mem_we_d;
    logic [12:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wmask_q, mem_wmask_d;
    logic          idle_q, idle_d;
    logic [12:0]   fifo_addr_q [FIFO_DEPTH];
    logic [7:0]    fifo_mask_q [FIFO_DEPTH];

    logic [12:0]   pix_addr_s;
    logic [7:0]    pix_bit_s;
    logic          push_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          drop_s;

    // Accumulator, deferred flush and idle-timeout: decides when the pending byte is pushed.
    always_comb begin
        pix_addr_s = {yo, xo[7:3]};
        pix_bit_s  = 8'd1 << xo[2:0];
        acc_addr_d = acc_addr_q;
        acc_mask_d = acc_mask_q;
        acc_v_d    = acc_v_q;
        dfl_d      = dfl_q;
        tmo_d      = 8'd0;
        push_s     = 1'b0;
        if (po) begin
            dfl_d      = dfl_q | flush;
            acc_v_d    = 1'b1;
            acc_addr_d = pix_addr_s;
            if (acc_v_q && (acc_addr_q == pix_addr_s)) begin
                acc_mask_d = acc_mask_q | pix_bit_s;
            end else begin
                acc_mask_d = pix_bit_s;
                push_s     = acc_v_q;
            end
        end else if (flush || dfl_q) begin
            push_s  = acc_v_q;
            acc_v_d = 1'b0;
            dfl_d   = 1'b0;
        end else if (acc_v_q && TMO_EN) begin
            if (tmo_q == TMO_LAST) begin
                push_s  = 1'b1;
                acc_v_d = 1'b0;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end else begin
            tmo_d = 8'd0;
        end
    end

    // FIFO bookkeeping; a pop in the same cycle makes room for a push into a full FIFO.
    always_comb begin
        pop_s   = (cnt_q != CNT_ZERO) && mem_ready;
        wr_en_s = push_s && ((cnt_q != FULL_CNT) || pop_s);
        drop_s  = push_s && !wr_en_s;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Next-state view of the FIFO head so the RAM-side outputs come straight from flops.
    always_comb begin
        mem_we_d = (cnt_d != CNT_ZERO);
        idle_d   = !acc_v_d && (cnt_d == CNT_ZERO) && !dfl_d;
        if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            mem_addr_d  = acc_addr_q;
            mem_wmask_d = acc_mask_q;
        end else begin
            mem_addr_d  = fifo_addr_q[rd_ptr_d];
            mem_wmask_d = fifo_mask_q[rd_ptr_d];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_addr_q  <= 13'd0;
            acc_mask_q  <= 8'd0;
            acc_v_q     <= 1'b0;
            dfl_q       <= 1'b0;
            tmo_q       <= 8'd0;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            cnt_q       <= CNT_ZERO;
            ovf_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 13'd0;
            mem_wmask_q <= 8'd0;
            idle_q      <= 1'b1;
        end else begin
            acc_addr_q  <= acc_addr_d;
            acc_mask_q  <= acc_mask_d;
            acc_v_q     <= acc_v_d;
            dfl_q       <= dfl_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wmask_q <= mem_wmask_d;
            idle_q      <= idle_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= 13'd0;
                fifo_mask_q[i] <= 8'd0;
            end
        end else if (wr_en_s) begin
            fifo_addr_q[wr_ptr_q] <= acc_addr_q;
            fifo_mask_q[wr_ptr_q] <= acc_mask_q;
        end
    end

`ifdef PIX_COUNT_EN
    logic [15:0] pix_count_q, pix_count_d;

    // Saturating pixel counter; a clr in the same cycle as a pixel leaves a count of one.
    always_comb begin
        if (clr) begin
            pix_count_d = po ? 16'd1 : 16'd0;
        end else if (po && (pix_count_q != 16'hFFFF)) begin
            pix_count_d = pix_count_q + 16'd1;
        end else begin
            pix_count_d = pix_count_q;
        end
    end

    // Pixel counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_count_q <= 16'd0;
        end else begin
            pix_count_q <= pix_count_d;
        end
    end

    assign pix_count = pix_count_q;
`endif

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = 8'hFF;
    assign overflow  = ovf_q;
    assign idle      = idle_q;

endmodule

// File: doc/pixel_pack_writer.md
Name: pixel_pack_writer

Overview:
- Downstream consumer of the trapezoid renderer's pixel stream (po/xo/yo).
- Packs consecutive pixels that fall in the same 8-pixel byte of a 1-bpp 256x256 bitmap into one masked byte write.
- Buffers packed writes in a small FIFO and drains them to a synchronous bitmap RAM port with a ready handshake.
- The renderer cannot be stalled, so FIFO overflow is detected and flagged rather than back-pressured.

Parameters:
- FIFO_DEPTH, 4, packed-write FIFO entries; power of 2, >=2.
- TIMEOUT, 16, idle cycles with no po before a partial byte is auto-flushed; 0 disables auto-flush; max 255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- po  in  1  pixel valid strobe from renderer.
- xo  in  8  pixel x.
- yo  in  8  pixel y.
- flush  in  1  single-cycle pulse: push pending partial byte (driven at end of each trapezoid).
- clr  in  1  synchronous clear of overflow (and pix_count when enabled).
- mem_we  out  1  write request; asserted while FIFO non-empty.
- mem_addr  out  13  byte address {y[7:0], x[7:3]}.
- mem_wdata  out  8  always 8'hFF.
- mem_wmask  out  8  bit enables; bit i = pixel x[2:0]==i (LSB = leftmost).
- mem_ready  in  1  RAM accepts the write this cycle.
- overflow  out  1  sticky: a packed word was dropped.
- idle  out  1  accumulator empty, FIFO empty, no deferred flush.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wmask=0, overflow=0, idle=1, accumulator empty, FIFO empty, timeout counter 0. mem_wdata is constant 8'hFF.
- Accumulator holds acc_addr[12:0], acc_mask[7:0] and acc_v. All updates occur at the clock edge.
- Pixel handling when po=1 at an edge:
  - acc_v=0: load addr={yo,xo[7:3]}, mask=1<<xo[2:0], set acc_v.
  - acc_v=1 and same addr: mask |= 1<<xo[2:0]. A duplicate pixel is harmless.
  - acc_v=1 and different addr: push {acc_addr,acc_mask} to the FIFO, then load the new pixel. One push per cycle maximum.
- Flush handling:
  - flush=1 and po=0: push the accumulator if acc_v, then clear acc_v. With acc_v=0 it is a no-op.
  - flush=1 and po=1 in the same cycle: the pixel is processed as above and a deferred-flush flag is set. The flush executes next cycle. If po is also high that next cycle, the pixel is processed and the flag stays set until a po=0 cycle.
- Timeout:
  - Counter clears on po, on flush, or when acc_v=0; otherwise it increments while acc_v=1.
  - When the counter reaches TIMEOUT (TIMEOUT!=0), the accumulator is pushed as for flush and the counter clears.
- FIFO:
  - mem_we/mem_addr/mem_wmask present the head entry directly from registers.
  - A push at the edge ending cycle k makes the entry visible at the earliest in cycle k+1. Minimum latency from the last pixel of a byte to mem_we is 1 cycle after the push trigger.
  - Pop when mem_we & mem_ready. Push and pop in the same cycle are both allowed, including when the FIFO is full: the pop frees the slot and no overflow occurs.
  - Push when full with no pop: the entry is dropped, overflow is set, and FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- clr clears overflow. The same edge still sets overflow if a drop occurs in that cycle (set wins).
- Reset mid-operation discards the accumulator, FIFO and deferred flush immediately; mem_we drops asynchronously.
- No combinational path from po/xo/yo to any output.

Optional Feature:
- Macro PIX_COUNT_EN.
- Defined:
  - Adds output pix_count [15:0], counting every cycle with po=1, including duplicates and pixels whose packed word is later dropped.
  - Saturates at 16'hFFFF. clr zeroes it; reset zeroes it.
  - If clr and po occur in the same cycle, the result is 1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Pixels (8,3),(9,3),(15,3), then flush, mem_ready=1 → single write: addr={8'd3,5'd1}=13'h061, wmask=8'h83, one cycle after the flush edge; idle=1 afterwards.
- Pixels (7,0),(8,0) on consecutive cycles, no flush, TIMEOUT=16 → write addr 0 mask 8'h80 issued first; addr 1 mask 8'h01 pushed after 16 idle cycles.
- flush and po=(0,5) in the same cycle, acc empty → deferred flush; write addr 13'h0A0 mask 8'h01 appears two cycles later.
- mem_ready=0, 6 pixels in distinct bytes plus flush, FIFO_DEPTH=4 → 4 entries retained and overflow=1. Raise mem_ready → exactly 4 writes in push order. clr → overflow=0.
- FIFO full, mem_ready=1, push arriving in the same cycle as a pop → no overflow; entry order preserved.
- PIX_COUNT_EN: 5 po pulses including 1 duplicate → pix_count=5; clr with po high → pix_count=1. Reset asserted mid-stream → all outputs at reset values, no further mem_we.
